// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a first-word-fall-through TX FIFO
// and shifts them out as start / 8 data / optional parity / 1-2 stop frames.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BAUD_WIDTH = 20
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic [3:0]            Cntrl,
  input  logic [BAUD_WIDTH-1:0] BaudDiv,
  input  logic                  Empty,
  input  logic [DATA_WIDTH-1:0] RData,
  output logic                  RInc,
  output logic                  TXD,
  output logic                  Busy
);

  localparam int unsigned NBITS = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BAUD_WIDTH-1:0]   baud_q;
  logic [NBITS-1:0]        data_q;
  logic                    par_en_q, par_odd_q, two_stop_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    stop2_q, stop2_d;
  logic                    txd_q, txd_d;
  logic                    busy_q;
  logic                    parity_bit;

  // Only the low byte of the FIFO word is serialized.
  logic unused_rdata;
  assign unused_rdata = ^RData;

  assign parity_bit = (^data_q) ^ par_odd_q;
  assign TXD        = txd_q;
  assign Busy       = busy_q;

  // Next-state, bit timing and next TXD value; RInc is the pop strobe itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop2_d = stop2_q;
    txd_d   = txd_q;
    RInc    = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (Cntrl[0] && !Empty && !reset) begin
          RInc    = 1'b1;
          state_d = START;
          cnt_d   = BaudDiv;
          idx_d   = '0;
          stop2_d = 1'b0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = baud_q;
          idx_d   = '0;
          txd_d   = data_q[0];
        end else begin
          cnt_d = cnt_q - BAUD_WIDTH'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = baud_q;
          if (idx_q == IDX_W'(NBITS - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = parity_bit;
            end else begin
              state_d = STOP;
              stop2_d = 1'b0;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            txd_d = data_q[idx_q + IDX_W'(1)];
          end
        end else begin
          cnt_d = cnt_q - BAUD_WIDTH'(1);
        end
      end
      PARITY: begin
        if (cnt_q == '0) begin
          state_d = STOP;
          cnt_d   = baud_q;
          stop2_d = 1'b0;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - BAUD_WIDTH'(1);
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (cnt_q == '0) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
            cnt_d   = baud_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - BAUD_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // State, counters and frame registers; frame config is captured only on a pop.
  always_ff @(posedge UCLK) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      baud_q     <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      idx_q      <= '0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop2_q <= stop2_d;
      txd_q   <= txd_d;
      busy_q  <= (state_d != IDLE);
      if (RInc) begin
        data_q     <= RData[NBITS-1:0];
        par_en_q   <= Cntrl[1];
        par_odd_q  <= Cntrl[2];
        two_stop_q <= Cntrl[3];
        baud_q     <= BaudDiv;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a FIFO model feeds words, expected
// frames are queued at load time and a negedge monitor checks TXD per cycle.
module tb_uart_tx_serializer;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 20;

  logic          UCLK = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    Cntrl = 4'b0000;
  logic [BW-1:0] BaudDiv = '0;
  logic          Empty = 1'b1;
  logic [DW-1:0] RData = '0;
  logic          RInc, TXD, Busy;

  uart_tx_serializer #(.DATA_WIDTH(DW), .BAUD_WIDTH(BW)) dut (
    .UCLK(UCLK), .reset(reset), .Cntrl(Cntrl), .BaudDiv(BaudDiv),
    .Empty(Empty), .RData(RData), .RInc(RInc), .TXD(TXD), .Busy(Busy)
  );

  always #5 UCLK = ~UCLK;

  typedef struct {
    logic [7:0]  d;
    logic        par_en;
    logic        par;
    logic        two_stop;
    int unsigned baud;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] fifo[$];
  logic       cyc_q[$];

  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  bit   mon_en = 0;
  bit   pop_pend = 0;
  logic prev_rinc = 1'b0;
  logic e_bit;
  bit   was_idle;
  frame_t cur;

  function automatic void fifo_outs();
    Empty = (fifo.size() == 0);
    RData = Empty ? 32'h0 : {24'hC0FFEE, fifo[0]};
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bit(input logic b, input int unsigned n);
    repeat (n) cyc_q.push_back(b);
  endtask

  // FIFO pops just after the edge at which the DUT captured the head word.
  always begin
    @(posedge UCLK);
    #1;
    if (pop_pend) begin
      pop_pend = 0;
      if (fifo.size() > 0) fifo.delete(0);
      fifo_outs();
    end
  end

  // Monitor: compare this cycle, then react to a pop strobe or reset.
  always @(negedge UCLK) begin
    if (mon_en) begin
      was_idle = (cyc_q.size() == 0);
      if (!was_idle) begin
        e_bit = cyc_q.pop_front();
        check("frame_bit", {TXD, Busy, RInc}, {e_bit, 1'b1, 1'b0});
      end else begin
        check("idle", {TXD, Busy, 1'b0}, 3'b100);
      end
      if (reset) check("rinc_in_reset", {2'b00, RInc}, 3'b000);
      if (RInc === 1'b1) begin
        check("pop_cond", {1'b0, prev_rinc, Empty}, 3'b000);
        pops++;
        pop_pend = 1;
        if (was_idle) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: RInc with no expected frame at %0t", $time);
          end else begin
            cur = exp_q.pop_front();
            push_bit(1'b0, cur.baud + 1);
            for (int i = 0; i < 8; i++) push_bit(cur.d[i], cur.baud + 1);
            if (cur.par_en) push_bit(cur.par, cur.baud + 1);
            push_bit(1'b1, cur.baud + 1);
            if (cur.two_stop) push_bit(1'b1, cur.baud + 1);
          end
        end
      end
      prev_rinc = RInc;
      if (reset) cyc_q.delete();
    end
  end

  task automatic load(input logic [7:0] d, input logic [3:0] c, input int unsigned baud,
                      input logic par);
    frame_t nf;
    nf.d = d;
    nf.par_en = c[1];
    nf.par = par;
    nf.two_stop = c[3];
    nf.baud = baud;
    fifo.push_back(d);
    exp_q.push_back(nf);
    fifo_outs();
  endtask

  task automatic drive(input logic [3:0] c, input int unsigned baud);
    Cntrl = c;
    BaudDiv = BW'(baud);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge UCLK);
    #2;
  endtask

  task automatic wait_frames(input string name, input int unsigned remaining,
                             input int budget);
    int k = 0;
    while ((exp_q.size() > remaining || cyc_q.size() > 0) && k < budget) begin
      @(posedge UCLK);
      k++;
    end
    #2;
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, frames left %0d", name, k, exp_q.size());
    end
    cycles(3);
  endtask

  task automatic wait_pops(input string name, input int n, input int budget);
    int k = 0;
    while (pops < n && k < budget) begin
      @(posedge UCLK);
      k++;
    end
    #2;
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, pops %0d expected %0d", name, pops, n);
    end
  endtask

  initial begin
    fifo_outs();
    repeat (3) @(posedge UCLK);
    #2;
    mon_en = 1;
    cycles(2);
    reset = 1'b0;
    cycles(3);

    // Basic frame 0xA5, 4 cycles per bit
    drive(4'b0001, 3);
    load(8'hA5, 4'b0001, 3, 1'b0);
    wait_frames("basic", 0, 200);
    check_int("basic_pops", pops, 1);

    // Parity: even/odd on 0xA5, even on 0x01
    drive(4'b0011, 3);
    load(8'hA5, 4'b0011, 3, 1'b0);
    wait_frames("par_even_a5", 0, 200);
    drive(4'b0111, 3);
    load(8'hA5, 4'b0111, 3, 1'b1);
    wait_frames("par_odd_a5", 0, 200);
    drive(4'b0011, 3);
    load(8'h01, 4'b0011, 3, 1'b1);
    wait_frames("par_even_01", 0, 200);
    check_int("parity_pops", pops, 4);

    // Two stop bits, back-to-back frames at 1 cycle per bit
    drive(4'b1000, 0);
    load(8'h00, 4'b1001, 0, 1'b0);
    load(8'hFF, 4'b1001, 0, 1'b0);
    cycles(5);
    check_int("disabled_no_pop", pops, 4);
    drive(4'b1001, 0);
    wait_frames("b2b", 0, 100);
    check_int("b2b_pops", pops, 6);

    // Enable gating, then empty gating
    drive(4'b0000, 1);
    load(8'h5A, 4'b0001, 1, 1'b0);
    cycles(30);
    check_int("enable_gate", pops, 6);
    drive(4'b0001, 1);
    wait_frames("enable_release", 0, 100);
    check_int("enable_pops", pops, 7);
    cycles(30);
    check_int("empty_gate", pops, 7);

    // Mid-frame BaudDiv change and enable clear
    drive(4'b0001, 3);
    load(8'h3C, 4'b0001, 3, 1'b0);
    load(8'hC3, 4'b0001, 2, 1'b0);
    wait_pops("midframe_pop", 8, 50);
    cycles(10);
    drive(4'b0000, 7);
    wait_frames("midframe", 1, 300);
    cycles(20);
    check_int("disable_hold", pops, 8);
    drive(4'b0001, 2);
    wait_frames("resume", 0, 200);
    check_int("resume_pops", pops, 9);

    // Reset during data bit 3 aborts the frame; next word pops after release
    drive(4'b0001, 3);
    load(8'h81, 4'b0001, 3, 1'b0);
    load(8'h7E, 4'b0001, 3, 1'b0);
    wait_pops("abort_pop", 10, 50);
    cycles(17);
    reset = 1'b1;
    cycles(3);
    check_int("reset_no_pop", pops, 10);
    reset = 1'b0;
    wait_frames("after_reset", 0, 300);
    check_int("after_reset_pops", pops, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the TX FIFO read-data word.
REQ-002 The block SHALL have parameter BAUD_WIDTH, default 20, giving the width of the baud divisor.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port UCLK, input, 1 bit: UART clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port Cntrl, input, 4 bits: [0] TxEnable, [1] ParityEn, [2] ParityOdd (1 = odd, 0 = even), [3] TwoStop.
REQ-007 The block SHALL have port BaudDiv, input, BAUD_WIDTH bits: bit period minus one, in UCLK cycles.
REQ-008 The block SHALL have port Empty, input, 1 bit: TX FIFO empty flag.
REQ-009 The block SHALL have port RData, input, DATA_WIDTH bits: FIFO head word (first-word fall-through, valid while Empty = 0); only RData[7:0] is transmitted.
REQ-010 The block SHALL have port RInc, output, 1 bit: one-cycle FIFO pop strobe.
REQ-011 The block SHALL have port TXD, output, 1 bit: serial line, idle high.
REQ-012 The block SHALL have port Busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-014 In IDLE with Cntrl[0] = 1 and Empty = 0, the block SHALL drive RInc = 1 for exactly that cycle.
REQ-015 In that same cycle the block SHALL latch RData[7:0], Cntrl[3:1] and BaudDiv into internal frame registers, and SHALL go to START.
REQ-016 RInc SHALL never assert outside IDLE, never while Empty = 1, and never on two consecutive cycles.
REQ-017 Each of START, DATA-bit, PARITY and STOP-bit SHALL last latched BaudDiv + 1 cycles, timed by a down-counter reloaded at each bit boundary.
REQ-018 BaudDiv = 0 SHALL give 1 cycle per bit; arithmetic SHALL be unsigned BAUD_WIDTH-bit with no overflow.
REQ-019 TXD SHALL be registered: 0 in START; the data bits LSB first (bit 0 to bit 7) in DATA; the parity bit in PARITY; 1 in STOP and IDLE.
REQ-020 The first cycle of TXD = 0 SHALL be the cycle after the RInc cycle.
REQ-021 DATA SHALL count 8 bits with a 3-bit index; after bit 7 it SHALL go to PARITY if latched ParityEn = 1, else to STOP.
REQ-022 The parity bit SHALL be XOR of the 8 data bits, XORed with latched ParityOdd.
REQ-023 STOP SHALL last 1 bit period, or 2 bit periods if latched TwoStop = 1; it SHALL then go to IDLE.
REQ-024 Back-to-back frames: from the last STOP cycle the block SHALL go to IDLE for one cycle, pop there if the IDLE conditions hold, and start the next START on the following cycle; the inter-frame gap is therefore exactly 1 UCLK of TXD = 1 beyond the stop period(s).
REQ-025 Changes to Cntrl or BaudDiv during a frame SHALL have no effect until the next IDLE pop.
REQ-026 Clearing Cntrl[0] mid-frame SHALL let the current frame complete, after which the block SHALL stay in IDLE.
REQ-027 The FIFO word SHALL be consumed only by the RInc pulse; Empty going to 1 mid-frame SHALL not affect the frame in progress.

Reset
REQ-028 While reset = 1 at a rising UCLK edge, the block SHALL load state = IDLE, TXD = 1, RInc = 0 and Busy = 0, and SHALL clear the counters and frame registers.
REQ-029 Reset mid-frame SHALL abort the frame: TXD = 1 from the next cycle and no RInc; the aborted word is lost, not re-popped.
REQ-030 On the first cycle after reset deasserts, the block SHALL pop only if Cntrl[0] = 1 and Empty = 0.

Verification
REQ-031 Basic frame: BaudDiv = 3, Cntrl = 4'b0001, one word 0xA5 -> one RInc pulse; from the next cycle TXD = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); Busy = 0 afterwards.
REQ-032 Parity: 0xA5 with Cntrl = 4'b0011 (even) -> parity bit 0, frame 11 bits; with Cntrl = 4'b0111 (odd) -> parity bit 1; with 0x01 and even parity -> parity bit 1.
REQ-033 Two stop bits and back-to-back: BaudDiv = 0, Cntrl = 4'b1001, FIFO holds 0x00 then 0xFF -> frame 1 is TXD 0 followed by 8 zeros then 1,1; exactly one idle cycle of TXD = 1; then frame 2; exactly 2 RInc pulses.
REQ-034 Enable and empty gating: Cntrl[0] = 0 with Empty = 0 -> RInc stays 0 and TXD stays 1 indefinitely; Cntrl[0] = 1 with Empty = 1 -> same.
REQ-035 Mid-frame disturbances: changing BaudDiv from 3 to 7 during DATA -> the remainder of the frame keeps 4-cycle bits; asserting reset during bit 3 -> TXD = 1 and Busy = 0 on the next cycle, and no RInc until reset releases.
